// File: rtl/adsr_pkg.sv
// adsr_pkg: shared types and constants for the ADSR envelope generator.
//   DW, ATK_OVS_SHIFT : default data width and attack overshoot shift
//   FULL, TGT         : full-scale level and attack target at the default width
//   state_t           : envelope phase encoding driven onto state_out
package adsr_pkg;

    localparam int unsigned DW            = 32;
    localparam int unsigned ATK_OVS_SHIFT = 2;
    localparam int unsigned STATE_W       = 3;
    localparam int unsigned K_W           = 4;

    localparam logic [DW-1:0] FULL = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW:0]   TGT  = {1'b0, FULL} + ({1'b0, FULL} >> ATK_OVS_SHIFT);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: control, audio and status bundle of the envelope generator.
//   master : note/gate controller side (drives sample_en, gate, k's, sustain, audio_in)
//   slave  : envelope generator side (drives env_out, state_out, busy, audio_out, audio_valid)
interface adsr_envelope_if #(
    parameter int unsigned DW = adsr_pkg::DW
);
    import adsr_pkg::*;

    logic                sample_en;
    logic                gate;
    logic [K_W-1:0]      attack_k;
    logic [K_W-1:0]      decay_k;
    logic [DW-2:0]       sustain_lvl;
    logic [K_W-1:0]      release_k;
    logic [DW-1:0]       audio_in;
    logic [DW-1:0]       env_out;
    logic [STATE_W-1:0]  state_out;
    logic                busy;
    logic [DW-1:0]       audio_out;
    logic                audio_valid;

    modport master (
        output sample_en, gate, attack_k, decay_k, sustain_lvl, release_k, audio_in,
        input  env_out, state_out, busy, audio_out, audio_valid
    );

    modport slave (
        input  sample_en, gate, attack_k, decay_k, sustain_lvl, release_k, audio_in,
        output env_out, state_out, busy, audio_out, audio_valid
    );

endinterface

// File: rtl/adsr_envelope_env_step.sv
// env_step: one first-order exponential step, (a-b)>>>k at full signed width.
//   a, b : signed operands (W bits)
//   k    : shift constant
//   step : (a-b)>>>k
//   zero : step == 0
module env_step #(
    parameter int unsigned W = adsr_pkg::DW + 1
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic        [3:0]   k,
    output logic signed [W-1:0] step,
    output logic                zero
);

    logic signed [W-1:0] diff;

    assign diff = a - b;
    assign step = diff >>> k;
    assign zero = (step == '0);

endmodule

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope advanced once per audio sample strobe,
// with an optional VCA applying the envelope to audio_in.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : adsr_envelope_if.slave (sample_en, gate, k's, sustain_lvl, audio_in in;
//                env_out, state_out, busy, audio_out, audio_valid out)
// Optional feature: define ADSR_VCA_EN to build the audio multiplier; otherwise
// audio_out and audio_valid are tied to zero.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int unsigned DW            = adsr_pkg::DW,
    parameter int unsigned ATK_OVS_SHIFT = adsr_pkg::ATK_OVS_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    adsr_envelope_if.slave    bus
);

    localparam int unsigned       W      = DW + 1;
    localparam logic [DW-1:0]     FULL_V = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [W-1:0] FULL_X = {1'b0, FULL_V};
    localparam logic signed [W-1:0] TGT_X  = FULL_X + (FULL_X >>> ATK_OVS_SHIFT);

    state_t              state_q, state_d, entered;
    logic [DW-1:0]       env_q, env_d;
    logic                gate_q;
    logic                busy_q;

    logic signed [W-1:0] env_x, sus_x;
    logic signed [W-1:0] sa, sb, step, add_x, sub_x;
    logic [K_W-1:0]      sk;
    logic                zero;

    assign env_x = {1'b0, env_q};
    assign sus_x = {2'b00, bus.sustain_lvl};
    assign add_x = env_x + step;
    assign sub_x = env_x - step;

    // Single shared step unit, operands chosen by the phase being entered
    env_step #(.W(W)) u_step (
        .a    (sa),
        .b    (sb),
        .k    (sk),
        .step (step),
        .zero (zero)
    );

    // Next-state and next-envelope logic
    always_comb begin
        entered = state_q;
        state_d = state_q;
        env_d   = env_q;
        sa      = '0;
        sb      = '0;
        sk      = '0;

        // Gate edges override the current phase in the sample they are seen
        if (bus.gate && !gate_q) begin
            entered = ST_ATTACK;
        end else if (!bus.gate && gate_q &&
                     (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            entered = ST_RELEASE;
        end

        case (entered)
            ST_ATTACK:  begin sa = TGT_X; sb = env_x; sk = bus.attack_k;  end
            ST_DECAY:   begin sa = env_x; sb = sus_x; sk = bus.decay_k;   end
            ST_RELEASE: begin sa = env_x; sb = '0;    sk = bus.release_k; end
            default:    ;
        endcase

        if (bus.sample_en) begin
            state_d = entered;
            case (entered)
                ST_IDLE: env_d = '0;
                ST_ATTACK: begin
                    // Overshooting target guarantees the attack reaches FULL
                    if (add_x >= FULL_X) begin
                        env_d   = FULL_V;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = DW'(add_x);
                    end
                end
                ST_DECAY: begin
                    // Landing on or below sustain (e.g. k=0) ends the phase at once
                    if (zero || env_x <= sus_x || sub_x <= sus_x) begin
                        env_d   = {1'b0, bus.sustain_lvl};
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = DW'(sub_x);
                    end
                end
                ST_SUSTAIN: env_d = {1'b0, bus.sustain_lvl};
                ST_RELEASE: begin
                    if (zero || sub_x <= '0) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = DW'(sub_x);
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, envelope and gate history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            busy_q  <= (state_d != ST_IDLE);
            if (bus.sample_en) begin
                gate_q <= bus.gate;
            end
        end
    end

    assign bus.env_out   = env_q;
    assign bus.state_out = state_q;
    assign bus.busy      = busy_q;

`ifdef ADSR_VCA_EN
    localparam int unsigned PW = 2 * DW;

    logic signed [PW-1:0] prod;
    logic [DW-1:0]        audio_q;
    logic                 aval_q;

    // Scale by the envelope held before this sample's update
    assign prod = PW'($signed(bus.audio_in)) * PW'($signed(env_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_q <= '0;
            aval_q  <= 1'b0;
        end else begin
            aval_q <= bus.sample_en;
            if (bus.sample_en) begin
                audio_q <= DW'(prod >>> (DW - 1));
            end
        end
    end

    assign bus.audio_out   = audio_q;
    assign bus.audio_valid = aval_q;
`else
    assign bus.audio_out   = '0;
    assign bus.audio_valid = 1'b0;
`endif

endmodule
